// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - RV32M multiply sequencer: op decode, multiplier token hold, result word select
// and a one-entry product cache.
module mul_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             mul_go,
    output logic             mul_sign0,
    output logic             mul_sign1,
    output logic [31:0]      mul_m,
    output logic [31:0]      mul_r,
    input  logic             mul_done,
    input  logic [63:0]      mul_result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;

    if (MUL_LATENCY < 1) begin : g_lat_check
        $error("mul_ctrl: MUL_LATENCY must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic             is_mul_q, is_mul_d;
    logic [31:0]      m_q, m_d;
    logic [31:0]      r_q, r_d;
    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      data_q, data_d;

    logic             cv_q, cv_d;
    logic [31:0]      ca_q, ca_d;
    logic [31:0]      cb_q, cb_d;
    logic             cs0_q, cs0_d;
    logic             cs1_q, cs1_d;
    logic [63:0]      cprod_q, cprod_d;

    logic             req_s0;
    logic             req_s1;
    logic             req_is_mul;
    logic             accept;
    logic             cache_hit;
    logic [31:0]      hit_word;
    logic [31:0]      done_word;

    always_comb begin
        req_s0     = (req_op == OP_MULH) || (req_op == OP_MULHSU);
        req_s1     = (req_op == OP_MULH);
        req_is_mul = (req_op == OP_MUL);
    end

    // The low word does not depend on operand signedness, so MUL may reuse any cached product.
    always_comb begin
        cache_hit = cv_q && (req_a == ca_q) && (req_b == cb_q) &&
                    (req_is_mul || ((req_s0 == cs0_q) && (req_s1 == cs1_q)));
        hit_word  = req_is_mul ? cprod_q[31:0] : cprod_q[63:32];
        done_word = is_mul_q ? mul_result[31:0] : mul_result[63:32];
    end

    assign req_ready  = (state_q == S_IDLE) && !kill;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == S_RESP);
    assign mul_go     = (state_q == S_BUSY) || (state_q == S_DRAIN);
    assign resp_data  = data_q;
    assign resp_tag   = tag_q;
    assign mul_m      = m_q;
    assign mul_r      = r_q;
    assign mul_sign0  = s0_q;
    assign mul_sign1  = s1_q;

    always_comb begin
        state_d  = state_q;
        is_mul_d = is_mul_q;
        m_d      = m_q;
        r_d      = r_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        tag_d    = tag_q;
        data_d   = data_q;
        cv_d     = cv_q;
        ca_d     = ca_q;
        cb_d     = cb_q;
        cs0_d    = cs0_q;
        cs1_d    = cs1_q;
        cprod_d  = cprod_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_mul_d = req_is_mul;
                    m_d      = req_a;
                    r_d      = req_b;
                    s0_d     = req_s0;
                    s1_d     = req_s1;
                    tag_d    = req_tag;
                    if (cache_hit) begin
                        data_d  = hit_word;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    cv_d    = 1'b1;
                    ca_d    = m_q;
                    cb_d    = r_q;
                    cs0_d   = s0_q;
                    cs1_d   = s1_q;
                    cprod_d = mul_result;
                    if (kill) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = done_word;
                        state_d = S_RESP;
                    end
                end else if (kill) begin
                    state_d = S_DRAIN;
                end
            end
            // Keep go asserted until the token wraps so the multiplier stays aligned for the next op.
            S_DRAIN: begin
                if (mul_done) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (kill || resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            is_mul_q <= 1'b0;
            m_q      <= '0;
            r_q      <= '0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            tag_q    <= '0;
            data_q   <= '0;
            cv_q     <= 1'b0;
            ca_q     <= '0;
            cb_q     <= '0;
            cs0_q    <= 1'b0;
            cs1_q    <= 1'b0;
            cprod_q  <= '0;
        end else begin
            state_q  <= state_d;
            is_mul_q <= is_mul_d;
            m_q      <= m_d;
            r_q      <= r_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            cv_q     <= cv_d;
            ca_q     <= ca_d;
            cb_q     <= cb_d;
            cs0_q    <= cs0_d;
            cs1_q    <= cs1_d;
            cprod_q  <= cprod_d;
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - directed bench for mul_ctrl with a token-ring multiplier stand-in
// and an arithmetic reference model.
module tb_mul_ctrl;

    localparam int LAT = 4;
    localparam int TW  = 5;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [TW-1:0] req_tag;
    logic          kill;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic [TW-1:0] resp_tag;
    logic          mul_go;
    logic          mul_sign0;
    logic          mul_sign1;
    logic [31:0]   mul_m;
    logic [31:0]   mul_r;
    logic          mul_done;
    logic [63:0]   mul_result;

    mul_ctrl #(.MUL_LATENCY(LAT), .TAG_W(TW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .mul_go     (mul_go),
        .mul_sign0  (mul_sign0),
        .mul_sign1  (mul_sign1),
        .mul_m      (mul_m),
        .mul_r      (mul_r),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] ext(input logic [31:0] v, input logic s);
        return s ? {{32{v[31]}}, v} : {32'b0, v};
    endfunction

    function automatic logic op_s0(input logic [1:0] op);
        return (op == 2'd1) || (op == 2'd2);
    endfunction

    function automatic logic op_s1(input logic [1:0] op);
        return (op == 2'd1);
    endfunction

    function automatic logic [31:0] ref_word(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = ext(a, op_s0(op)) * ext(b, op_s1(op));
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier stand-in: token walks LAT+1 positions while go is high, done at the last one.
    logic [2:0] tok;
    always @(posedge clk) begin
        if (!reset_n) tok <= 3'd0;
        else if (mul_go) tok <= (tok == 3'(LAT)) ? 3'd0 : tok + 3'd1;
    end
    assign mul_done   = mul_go && (tok == 3'(LAT));
    assign mul_result = ext(mul_m, mul_sign0) * ext(mul_r, mul_sign1);

    // Reference cache of the last completed multiply.
    logic        mc_v;
    logic [31:0] mc_a, mc_b;
    logic        mc_s0, mc_s1;

    function automatic bit model_hit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return mc_v && (a == mc_a) && (b == mc_b) &&
               ((op == 2'd0) || ((op_s0(op) == mc_s0) && (op_s1(op) == mc_s1)));
    endfunction

    logic          exp_pending;
    logic [31:0]   exp_a, exp_b, exp_data;
    logic          exp_s0, exp_s1;
    logic [TW-1:0] exp_tag;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (resp_valid) begin
                if (!exp_pending) begin
                    chk("spurious_resp", resp_valid, 1'b0);
                end else begin
                    chk("cmp_resp_data", resp_data, exp_data);
                    chk("cmp_resp_tag", resp_tag, exp_tag);
                end
            end
            if (mul_go) begin
                chk("cmp_mul_m", mul_m, exp_a);
                chk("cmp_mul_r", mul_r, exp_b);
                chk("cmp_sign0", mul_sign0, exp_s0);
                chk("cmp_sign1", mul_sign1, exp_s1);
            end
        end
    end

    task automatic set_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag);
        exp_a    = a;
        exp_b    = b;
        exp_s0   = op_s0(op);
        exp_s1   = op_s1(op);
        exp_data = ref_word(op, a, b);
        exp_tag  = tag;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TW-1:0] tag, input logic [31:0] lit, input int hold,
                           input bit kill_resp, input string nm);
        bit hit;
        int lat;
        int gos;
        hit = model_hit(op, a, b);
        set_exp(op, a, b, tag);
        exp_pending = 1'b1;
        chk({nm, "_req_ready"}, req_ready, 1'b1);
        drive_req(op, a, b, tag);
        lat = 0;
        gos = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mul_go) gos++;
        end while (!resp_valid && lat < 40);
        chk({nm, "_latency"}, lat, hit ? 1 : LAT + 2);
        chk({nm, "_go_cycles"}, gos, hit ? 0 : LAT + 1);
        chk({nm, "_data"}, resp_data, lit);
        chk({nm, "_tag"}, resp_tag, tag);
        if (!hit) begin
            mc_v  = 1'b1;
            mc_a  = a;
            mc_b  = b;
            mc_s0 = op_s0(op);
            mc_s1 = op_s1(op);
        end
        repeat (hold) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, resp_valid, 1'b1);
            chk({nm, "_hold_req_ready"}, req_ready, 1'b0);
        end
        kill       = kill_resp;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        kill        = 1'b0;
        resp_ready  = 1'b0;
        exp_pending = 1'b0;
        @(negedge clk);
        chk({nm, "_after_valid"}, resp_valid, 1'b0);
        chk({nm, "_after_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gos;
        int n;
        clk         = 1'b0;
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_op      = 2'd0;
        req_a       = '0;
        req_b       = '0;
        req_tag     = '0;
        kill        = 1'b0;
        resp_ready  = 1'b0;
        exp_pending = 1'b0;
        mc_v        = 1'b0;
        mc_a        = '0;
        mc_b        = '0;
        mc_s0       = 1'b0;
        mc_s1       = 1'b0;
        set_exp(2'd0, 32'd0, 32'd0, '0);

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_mul_go", mul_go, 1'b0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_tag", resp_tag, '0);
        chk("rst_mul_m", mul_m, 32'h0);
        chk("rst_mul_r", mul_r, 32'h0);
        chk("rst_signs", {mul_sign0, mul_sign1}, 2'b00);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);

        run_req(2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 0, 1'b0, "mul_basic");
        run_req(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 0, 1'b0, "mulh");
        run_req(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 0, 1'b0, "mulhsu");
        run_req(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 0, 1'b0, "mulhu");
        run_req(2'd3, 32'h8000_0000, 32'h0000_0004, 5'd7, 32'h0000_0002, 0, 1'b0, "fuse_hi");
        run_req(2'd0, 32'h8000_0000, 32'h0000_0004, 5'd8, 32'h0000_0000, 0, 1'b0, "fuse_lo");
        run_req(2'd1, 32'h0001_0000, 32'h0001_0000, 5'd9, 32'h0000_0001, 10, 1'b0, "backpressure");

        kill      = 1'b1;
        req_valid = 1'b1;
        #1 chk("kill_idle_req_ready", req_ready, 1'b0);
        @(posedge clk);
        #1;
        kill      = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("kill_idle_no_go", mul_go, 1'b0);
        chk("kill_idle_no_resp", resp_valid, 1'b0);

        set_exp(2'd3, 32'hFFFF_0000, 32'h0001_0000, 5'd10);
        drive_req(2'd3, 32'hFFFF_0000, 32'h0001_0000, 5'd10);
        gos = 0;
        repeat (2) begin
            @(negedge clk);
            if (mul_go) gos++;
        end
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mul_go) gos++;
        end while (mul_go && n < 20);
        chk("kill_busy_go_cycles", gos, LAT + 1);
        repeat (4) begin
            @(negedge clk);
            chk("kill_busy_no_resp", resp_valid, 1'b0);
        end
        chk("kill_busy_req_ready", req_ready, 1'b1);

        run_req(2'd0, 32'd3, 32'd5, 5'd11, 32'd15, 0, 1'b0, "after_kill_mul");
        run_req(2'd3, 32'hFFFF_0000, 32'h0001_0000, 5'd12, 32'h0000_FFFF, 0, 1'b0, "killed_op_miss");

        run_req(2'd0, 32'd6, 32'd7, 5'd13, 32'd42, 0, 1'b1, "kill_resp");
        run_req(2'd0, 32'd6, 32'd7, 5'd14, 32'd42, 0, 1'b0, "kill_resp_cache_kept");

        set_exp(2'd0, 32'd9, 32'd9, 5'd15);
        drive_req(2'd0, 32'd9, 32'd9, 5'd15);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_mul_go", mul_go, 1'b0);
        chk("async_rst_resp_valid", resp_valid, 1'b0);
        chk("async_rst_mul_m", mul_m, 32'h0);
        chk("async_rst_mul_r", mul_r, 32'h0);
        chk("async_rst_resp_data", resp_data, 32'h0);
        chk("async_rst_resp_tag", resp_tag, '0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mc_v    = 1'b0;
        @(negedge clk);
        run_req(2'd0, 32'd2, 32'd2, 5'd16, 32'd4, 0, 1'b0, "post_reset_mul");
        run_req(2'd0, 32'd9, 32'd9, 5'd17, 32'd81, 0, 1'b0, "post_reset_cache_cold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
